// File: rtl/sram_test_seq.sv
// Sequencer that runs the data bus, address bus and device SRAM tests in order,
// muxing the active test onto the SRAM controller and guarding each test with a watchdog.
module sram_test_seq #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
   parameter logic [2:0]  SKIP_MASK      = 3'b000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        ready,
   input  logic [7:0]  data2fpga,
   output logic        mem,
   output logic        rw,
   output logic [19:0] addr,
   output logic [7:0]  data2ram,
   output logic [2:0]  t_en,
   output logic [2:0]  t_ready,
   input  logic [2:0]  t_mem,
   input  logic [2:0]  t_rw,
   input  logic [2:0]  t_done,
   input  logic [2:0]  t_result,
   input  logic [59:0] t_addr,
   input  logic [23:0] t_data2ram,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [1:0]  fail_test,
   output logic        timeout,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [1:0] FIRST_IDX = !SKIP_MASK[0] ? 2'd0 : (!SKIP_MASK[1] ? 2'd1 : 2'd2);

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [23:0] cnt_q, cnt_d;
   logic        pass_q, pass_d;
   logic [1:0]  fail_q, fail_d;
   logic        timeout_q, timeout_d;

   logic        sel_mem, sel_rw, sel_done, sel_result;
   logic [19:0] sel_addr;
   logic [7:0]  sel_data;
   logic [2:0]  sel_oh;
   logic        has_next;
   logic [1:0]  next_idx;

   // Read data goes straight to the tests; the sequencer never looks at it.
   logic unused_data2fpga;
   assign unused_data2fpga = ^data2fpga;

   always_comb begin
      sel_mem    = t_mem[0];
      sel_rw     = t_rw[0];
      sel_done   = t_done[0];
      sel_result = t_result[0];
      sel_addr   = t_addr[19:0];
      sel_data   = t_data2ram[7:0];
      sel_oh     = 3'b001;
      case (idx_q)
         2'd1: begin
            sel_mem    = t_mem[1];
            sel_rw     = t_rw[1];
            sel_done   = t_done[1];
            sel_result = t_result[1];
            sel_addr   = t_addr[39:20];
            sel_data   = t_data2ram[15:8];
            sel_oh     = 3'b010;
         end
         2'd2: begin
            sel_mem    = t_mem[2];
            sel_rw     = t_rw[2];
            sel_done   = t_done[2];
            sel_result = t_result[2];
            sel_addr   = t_addr[59:40];
            sel_data   = t_data2ram[23:16];
            sel_oh     = 3'b100;
         end
         default: ;
      endcase
   end

   always_comb begin
      has_next = 1'b0;
      next_idx = idx_q;
      if (idx_q == 2'd0 && !SKIP_MASK[1]) begin
         has_next = 1'b1;
         next_idx = 2'd1;
      end else if (idx_q != 2'd2 && !SKIP_MASK[2]) begin
         has_next = 1'b1;
         next_idx = 2'd2;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (SKIP_MASK == 3'b111) begin
                  state_d = S_DONE;
                  pass_d  = 1'b1;
                  fail_d  = 2'd3;
               end else begin
                  state_d = S_RUN;
                  idx_d   = FIRST_IDX;
                  cnt_d   = 24'd0;
               end
            end
         end
         S_RUN: begin
            // A finishing test wins over a watchdog expiry in the same cycle.
            if (sel_done) begin
               if (!sel_result) begin
                  state_d   = S_DONE;
                  pass_d    = 1'b0;
                  fail_d    = idx_q;
                  timeout_d = 1'b0;
               end else if (has_next) begin
                  state_d = S_GAP;
               end else begin
                  state_d = S_DONE;
                  pass_d  = 1'b1;
                  fail_d  = 2'd3;
               end
            end else if (cnt_q == TIMEOUT_CYCLES - 24'd1) begin
               state_d   = S_DONE;
               pass_d    = 1'b0;
               fail_d    = idx_q;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         S_GAP: begin
            state_d = S_RUN;
            idx_d   = next_idx;
            cnt_d   = 24'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= 2'd0;
         cnt_q     <= 24'd0;
         pass_q    <= 1'b0;
         fail_q    <= 2'd3;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         timeout_q <= timeout_d;
      end
   end

   // Controller-side outputs follow the active test with no register stage.
   always_comb begin
      mem      = 1'b0;
      rw       = 1'b1;
      addr     = 20'd0;
      data2ram = 8'd0;
      t_en     = 3'b000;
      t_ready  = 3'b000;
      if (state_q == S_RUN) begin
         mem      = sel_mem;
         rw       = sel_rw;
         addr     = sel_addr;
         data2ram = sel_data;
         t_en     = sel_oh;
         t_ready  = sel_oh & {3{ready}};
      end
   end

   assign busy        = (state_q == S_RUN) || (state_q == S_GAP);
   assign done        = (state_q == S_DONE);
   assign pass        = pass_q;
   assign fail_test   = fail_q;
   assign timeout     = timeout_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_test_seq.sv
// Directed bench for sram_test_seq: a vector table for the RUN-time muxing plus
// hand-written sequences for failure, watchdog, reset abort and skipped tests.
module tb_sram_test_seq;

   logic        clk, rst, start, ready;
   logic [7:0]  data2fpga;
   logic        mem, rw;
   logic [19:0] addr;
   logic [7:0]  data2ram;
   logic [2:0]  t_en, t_ready;
   logic [2:0]  t_mem, t_rw, t_done, t_result;
   logic [59:0] t_addr;
   logic [23:0] t_data2ram;
   logic        busy, done, pass, timeout;
   logic [1:0]  fail_test, dbg_state;

   logic        start_s;
   logic [2:0]  t_done_s, t_result_s;
   logic        mem_s, rw_s, busy_s, done_s, pass_s, timeout_s;
   logic [19:0] addr_s;
   logic [7:0]  data2ram_s;
   logic [2:0]  t_en_s, t_ready_s;
   logic [1:0]  fail_test_s, dbg_state_s;

   int n_vec = 0;
   int n_err = 0;
   int cur;
   logic en2_seen;

   sram_test_seq #(.TIMEOUT_CYCLES(24'd100), .SKIP_MASK(3'b000)) dut (
      .clk(clk), .rst(rst), .start(start), .ready(ready), .data2fpga(data2fpga),
      .mem(mem), .rw(rw), .addr(addr), .data2ram(data2ram),
      .t_en(t_en), .t_ready(t_ready),
      .t_mem(t_mem), .t_rw(t_rw), .t_done(t_done), .t_result(t_result),
      .t_addr(t_addr), .t_data2ram(t_data2ram),
      .busy(busy), .done(done), .pass(pass), .fail_test(fail_test),
      .timeout(timeout), .dbg_state_o(dbg_state)
   );

   sram_test_seq #(.TIMEOUT_CYCLES(24'd100), .SKIP_MASK(3'b010)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .ready(ready), .data2fpga(data2fpga),
      .mem(mem_s), .rw(rw_s), .addr(addr_s), .data2ram(data2ram_s),
      .t_en(t_en_s), .t_ready(t_ready_s),
      .t_mem(t_mem), .t_rw(t_rw), .t_done(t_done_s), .t_result(t_result_s),
      .t_addr(t_addr), .t_data2ram(t_data2ram),
      .busy(busy_s), .done(done_s), .pass(pass_s), .fail_test(fail_test_s),
      .timeout(timeout_s), .dbg_state_o(dbg_state_s)
   );

   // clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic [1:0]  phase;
      logic        ready;
      logic [2:0]  t_mem;
      logic [2:0]  t_rw;
      logic [59:0] t_addr;
      logic [23:0] t_data;
      logic        e_mem;
      logic        e_rw;
      logic [19:0] e_addr;
      logic [7:0]  e_data;
      logic [2:0]  e_en;
      logic [2:0]  e_rdy;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (t_en[2]) en2_seen = 1'b1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      start      = 1'b0;
      start_s    = 1'b0;
      ready      = 1'b0;
      t_mem      = 3'b000;
      t_rw       = 3'b000;
      t_done     = 3'b000;
      t_result   = 3'b000;
      t_done_s   = 3'b000;
      t_result_s = 3'b000;
      t_addr     = {20'h33333, 20'h22222, 20'h11111};
      t_data2ram = {8'hC3, 8'hB2, 8'hA1};
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Finish the current test successfully and walk through the one-cycle gap.
   task automatic advance();
      t_done[cur]   = 1'b1;
      t_result[cur] = 1'b1;
      step();
      check("gap_t_en", t_en, 3'b000);
      check("gap_busy", busy, 1'b1);
      step();
      cur = cur + 1;
   endtask

   initial begin
      vecs[0] = '{2'd0, 1'b1, 3'b001, 3'b110, {20'h33333, 20'h22222, 20'h11111}, {8'hC3, 8'hB2, 8'hA1},
                  1'b1, 1'b0, 20'h11111, 8'hA1, 3'b001, 3'b001};
      vecs[1] = '{2'd0, 1'b0, 3'b110, 3'b001, {20'h33333, 20'h22222, 20'h11111}, {8'hC3, 8'hB2, 8'hA1},
                  1'b0, 1'b1, 20'h11111, 8'hA1, 3'b001, 3'b000};
      vecs[2] = '{2'd0, 1'b1, 3'b000, 3'b000, {20'hFFFFF, 20'hFFFFF, 20'h00000}, {8'hFF, 8'hFF, 8'h00},
                  1'b0, 1'b0, 20'h00000, 8'h00, 3'b001, 3'b001};
      vecs[3] = '{2'd1, 1'b1, 3'b010, 3'b010, {20'h33333, 20'h22222, 20'h11111}, {8'hC3, 8'hB2, 8'hA1},
                  1'b1, 1'b1, 20'h22222, 8'hB2, 3'b010, 3'b010};
      vecs[4] = '{2'd1, 1'b1, 3'b101, 3'b101, {20'h33333, 20'h22222, 20'h11111}, {8'hC3, 8'hB2, 8'hA1},
                  1'b0, 1'b0, 20'h22222, 8'hB2, 3'b010, 3'b010};
      vecs[5] = '{2'd2, 1'b1, 3'b100, 3'b011, {20'h33333, 20'h22222, 20'h11111}, {8'hC3, 8'hB2, 8'hA1},
                  1'b1, 1'b0, 20'h33333, 8'hC3, 3'b100, 3'b100};
      vecs[6] = '{2'd2, 1'b0, 3'b011, 3'b100, {20'hABCDE, 20'h12345, 20'h54321}, {8'h5A, 8'h3C, 8'h96},
                  1'b0, 1'b1, 20'hABCDE, 8'h5A, 3'b100, 3'b000};

      data2fpga = 8'h5A;
      en2_seen  = 1'b0;

      // Reset values, with active-looking inputs that must not leak out.
      rst = 1'b1; start = 1'b0; start_s = 1'b0; ready = 1'b1;
      t_mem = 3'b111; t_rw = 3'b000; t_done = 3'b000; t_result = 3'b000;
      t_done_s = 3'b000; t_result_s = 3'b000;
      t_addr = {20'h33333, 20'h22222, 20'h11111};
      t_data2ram = {8'hC3, 8'hB2, 8'hA1};
      step();
      check("rst_mem", mem, 1'b0);
      check("rst_rw", rw, 1'b1);
      check("rst_addr", addr, 20'd0);
      check("rst_data", data2ram, 8'd0);
      check("rst_t_en", t_en, 3'b000);
      check("rst_t_ready", t_ready, 3'b000);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_pass", pass, 1'b0);
      check("rst_fail_test", fail_test, 2'd3);
      check("rst_timeout", timeout, 1'b0);

      // Table-driven muxing through all three tests, ending in overall pass.
      do_reset();
      cur = 0;
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         while (cur < int'(vecs[i].phase)) advance();
         ready      = vecs[i].ready;
         t_mem      = vecs[i].t_mem;
         t_rw       = vecs[i].t_rw;
         t_addr     = vecs[i].t_addr;
         t_data2ram = vecs[i].t_data;
         #1;
         check($sformatf("v%0d_mem", i), mem, vecs[i].e_mem);
         check($sformatf("v%0d_rw", i), rw, vecs[i].e_rw);
         check($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
         check($sformatf("v%0d_data", i), data2ram, vecs[i].e_data);
         check($sformatf("v%0d_t_en", i), t_en, vecs[i].e_en);
         check($sformatf("v%0d_t_ready", i), t_ready, vecs[i].e_rdy);
         check($sformatf("v%0d_busy", i), busy, 1'b1);
         step();
      end
      t_mem = 3'b111;
      t_done[2] = 1'b1;
      t_result[2] = 1'b1;
      step();
      check("all_done", done, 1'b1);
      check("all_pass", pass, 1'b1);
      check("all_fail_test", fail_test, 2'd3);
      check("all_timeout", timeout, 1'b0);
      check("all_busy", busy, 1'b0);
      check("all_mem", mem, 1'b0);
      check("all_t_en", t_en, 3'b000);
      start = 1'b1;
      step();
      step();
      start = 1'b0;
      check("done_sticky", done, 1'b1);
      check("done_sticky_state", dbg_state, 2'd3);

      // Test 1 reports failure; test 2 must never be enabled.
      do_reset();
      en2_seen = 1'b0;
      pulse_start();
      check("f_t_en0", t_en, 3'b001);
      t_done[0] = 1'b1; t_result[0] = 1'b1;
      step();
      step();
      check("f_t_en1", t_en, 3'b010);
      step(); step(); step();
      t_done[1] = 1'b1; t_result[1] = 1'b0;
      step();
      check("f_done", done, 1'b1);
      check("f_pass", pass, 1'b0);
      check("f_fail_test", fail_test, 2'd1);
      check("f_timeout", timeout, 1'b0);
      repeat (5) step();
      check("f_en2_never", en2_seen, 1'b0);

      // Watchdog: test 0 never finishes; DONE exactly 100 cycles after RUN entry.
      do_reset();
      t_mem = 3'b111;
      pulse_start();
      repeat (99) step();
      check("wd_busy_99", busy, 1'b1);
      check("wd_mem_99", mem, 1'b1);
      step();
      check("wd_done", done, 1'b1);
      check("wd_timeout", timeout, 1'b1);
      check("wd_fail_test", fail_test, 2'd0);
      check("wd_pass", pass, 1'b0);
      check("wd_mem", mem, 1'b0);
      repeat (3) step();
      check("wd_mem_later", mem, 1'b0);

      // Done arriving on the watchdog's last cycle wins.
      do_reset();
      pulse_start();
      repeat (99) step();
      t_done[0] = 1'b1; t_result[0] = 1'b1;
      step();
      check("prio_busy", busy, 1'b1);
      check("prio_done", done, 1'b0);
      check("prio_t_en", t_en, 3'b000);
      step();
      check("prio_t_en1", t_en, 3'b010);

      // Asynchronous reset while test 1 is active.
      do_reset();
      pulse_start();
      t_done[0] = 1'b1; t_result[0] = 1'b1;
      step();
      step();
      t_mem = 3'b111; ready = 1'b1;
      #1;
      check("ar_mem_before", mem, 1'b1);
      rst = 1'b1;
      #1;
      check("ar_mem", mem, 1'b0);
      check("ar_addr", addr, 20'd0);
      check("ar_t_en", t_en, 3'b000);
      check("ar_t_ready", t_ready, 3'b000);
      check("ar_busy", busy, 1'b0);
      check("ar_fail_test", fail_test, 2'd3);
      step();
      rst = 1'b0;
      step();
      check("ar_idle", dbg_state, 2'd0);

      // Skipped address bus test: 001, gap, 100.
      do_reset();
      start_s = 1'b1;
      step();
      start_s = 1'b0;
      check("s_t_en0", t_en_s, 3'b001);
      t_done_s[0] = 1'b1; t_result_s[0] = 1'b1;
      step();
      check("s_gap", t_en_s, 3'b000);
      step();
      check("s_t_en2", t_en_s, 3'b100);
      t_done_s[2] = 1'b1; t_result_s[2] = 1'b1;
      step();
      check("s_done", done_s, 1'b1);
      check("s_pass", pass_s, 1'b1);
      check("s_fail_test", fail_test_s, 2'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
